// File: rtl/timer_sched_pkg.sv
// Shared constants and types for the timer scheduler.
// The default prescaler divide gives a 10 ms base tick from a 50 MHz clock.
package timer_sched_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int TICK_DIV_10MS = CLK_HZ / 100;

    // Default channel count and the matching event-id width.
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CH_W   = $clog2(DEF_NUM_CH);

    // Event record as seen by software in the default four-channel build.
    typedef struct packed {
        logic [DEF_CH_W-1:0] id;
    } evt_t;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping
// modulo NUM_CH. Purely combinational so it can be shared by other blocks.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic              valid_o
);

    logic [CH_W-1:0] idx;
    logic            found;

    // Scan from the pointer upwards and take the first active request.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(ptr_i) + i) % NUM_CH);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel timeout scheduler on one shared base tick.
// A prescaler produces tick_out every TICK_DIV clocks; each channel counts
// ticks down and expiries are serialised onto one valid/ready event port
// through a round-robin arbiter. Define TIMER_SCHED_PERIODIC_EN to add the
// arm_periodic input and per-channel reload registers for auto-rearming.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = TICK_DIV_10MS
) (
    input  logic                       clock_in,
    input  logic                       reset_n,
    input  logic                       enable,
    output logic                       tick_out,
    input  logic                       arm_valid,
    output logic                       arm_ready,
    input  logic [$clog2(NUM_CH)-1:0]  arm_ch,
    input  logic [CNT_W-1:0]           arm_ticks,
`ifdef TIMER_SCHED_PERIODIC_EN
    input  logic                       arm_periodic,
`endif
    output logic [NUM_CH-1:0]          active,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_CH)-1:0]  evt_id,
    output logic [NUM_CH-1:0]          ovf,
    input  logic [NUM_CH-1:0]          ovf_clr
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int PS_W = $clog2(TICK_DIV);

    // Event register contents for this channel count.
    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] id;
    } evtSlot_t;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic              tick_q, tick_d;

    logic [CNT_W-1:0]  remain_q [NUM_CH];
    logic [CNT_W-1:0]  remain_d [NUM_CH];
    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] armHit, expire, cancel;
`ifdef TIMER_SCHED_PERIODIC_EN
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  reload_d [NUM_CH];
    logic [NUM_CH-1:0] periodic_q, periodic_d;
`endif

    evtSlot_t          evt_q, evt_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic              armFire, armCancel, portFree, grantValid;
    logic [NUM_CH-1:0] req, grant, grantEff;
    logic [CH_W-1:0]   grantId;

    // A running channel must be cancelled before it can be given a new count.
    assign armCancel = (arm_ticks == '0);
    assign arm_ready = ~active_q[arm_ch] | armCancel;
    assign armFire   = arm_valid & arm_ready;

    // Prescaler: free-runs while enabled and flags the wrap one cycle later.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (enable) begin
            if (presc_q == PS_W'(TICK_DIV - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end
    end

    // Per-channel countdown: an accepted arm/cancel overrides that channel's tick.
    always_comb begin
        active_d = active_q;
        armHit   = '0;
        expire   = '0;
        cancel   = '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        periodic_d = periodic_q;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            remain_d[k] = remain_q[k];
`ifdef TIMER_SCHED_PERIODIC_EN
            reload_d[k] = reload_q[k];
`endif
            armHit[k] = armFire && (arm_ch == CH_W'(k));
            if (armHit[k]) begin
                if (armCancel) begin
                    remain_d[k] = '0;
                    active_d[k] = 1'b0;
                    cancel[k]   = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
                    periodic_d[k] = 1'b0;
`endif
                end else begin
                    remain_d[k] = arm_ticks;
                    active_d[k] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
                    periodic_d[k] = arm_periodic;
                    reload_d[k]   = arm_ticks;
`endif
                end
            end else if (tick_q && active_q[k]) begin
                if (remain_q[k] == CNT_W'(1)) begin
                    expire[k] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
                    if (periodic_q[k]) begin
                        remain_d[k] = reload_q[k];
                    end else begin
                        remain_d[k] = '0;
                        active_d[k] = 1'b0;
                    end
`else
                    remain_d[k] = '0;
                    active_d[k] = 1'b0;
`endif
                end else begin
                    remain_d[k] = remain_q[k] - CNT_W'(1);
                end
            end
        end
    end

    // Fresh expiries bypass the pending register so a free port reports them next cycle.
    assign req = (pending_q | expire) & ~cancel;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .valid_o (grantValid)
    );

    // Event port, pending and overrun bookkeeping.
    always_comb begin
        portFree = ~evt_q.valid | evt_ready;
        grantEff = portFree ? grant : '0;
        grantId  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                grantId = CH_W'(k);
            end
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (cancel[k]) begin
                pending_d[k] = 1'b0;
            end else if (grantEff[k]) begin
                pending_d[k] = pending_q[k] & expire[k];
            end else begin
                pending_d[k] = pending_q[k] | expire[k];
            end
        end

        ovf_d = (ovf_q & ~ovf_clr) | (expire & pending_q & ~grantEff);

        evt_d = evt_q;
        ptr_d = ptr_q;
        if (portFree) begin
            evt_d.valid = grantValid;
            if (grantValid) begin
                evt_d.id = grantId;
                ptr_d    = (grantId == CH_W'(NUM_CH - 1)) ? '0 : grantId + CH_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            active_q  <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            evt_q     <= '0;
            ptr_q     <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                remain_q[k] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            evt_q     <= evt_d;
            ptr_q     <= ptr_d;
            for (int k = 0; k < NUM_CH; k++) begin
                remain_q[k] <= remain_d[k];
            end
        end
    end

`ifdef TIMER_SCHED_PERIODIC_EN
    // Reload values and periodic flags for auto-rearming channels.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            periodic_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                reload_q[k] <= '0;
            end
        end else begin
            periodic_q <= periodic_d;
            for (int k = 0; k < NUM_CH; k++) begin
                reload_q[k] <= reload_d[k];
            end
        end
    end
`endif

    assign tick_out  = tick_q;
    assign active    = active_q;
    assign ovf       = ovf_q;
    assign evt_valid = evt_q.valid;
    assign evt_id    = evt_q.id;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler with TICK_DIV=4, NUM_CH=4, CNT_W=8.
// Expected event ids go into a queue when a channel is armed; a monitor pops
// and compares whenever an event is handed over. Periodic scenarios are built
// only when TIMER_SCHED_PERIODIC_EN is defined.
module tb_timer_scheduler;

    logic       clock;
    logic       resetN;
    logic       enable;
    logic       tickOut;
    logic       armValid;
    logic       armReady;
    logic [1:0] armCh;
    logic [7:0] armTicks;
`ifdef TIMER_SCHED_PERIODIC_EN
    logic       armPeriodic;
`endif
    logic [3:0] active;
    logic       evtValid;
    logic       evtReady;
    logic [1:0] evtId;
    logic [3:0] ovf;
    logic [3:0] ovfClr;

    int checks = 0;
    int errors = 0;
    int unsigned expQ[$];

    timer_scheduler #(
        .NUM_CH   (4),
        .CNT_W    (8),
        .TICK_DIV (4)
    ) dut (
        .clock_in     (clock),
        .reset_n      (resetN),
        .enable       (enable),
        .tick_out     (tickOut),
        .arm_valid    (armValid),
        .arm_ready    (armReady),
        .arm_ch       (armCh),
        .arm_ticks    (armTicks),
`ifdef TIMER_SCHED_PERIODIC_EN
        .arm_periodic (armPeriodic),
`endif
        .active       (active),
        .evt_valid    (evtValid),
        .evt_ready    (evtReady),
        .evt_id       (evtId),
        .ovf          (ovf),
        .ovf_clr      (ovfClr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold an arm request for one cycle; the ready check happens before the edge.
    task automatic applyStimulus(input int ch, input int ticks, input int expReady);
        armValid = 1'b1;
        armCh    = 2'(ch);
        armTicks = 8'(ticks);
        #1;
        checkOutput("arm_ready", int'(armReady), expReady);
        @(posedge clock);
        #1;
        armValid = 1'b0;
        armTicks = '0;
    endtask

    // Advance until the cycle in which tick_out is high.
    task automatic waitForTick();
        int n = 0;
        do begin
            step();
            n++;
        end while (tickOut !== 1'b1 && n < 20);
        if (tickOut !== 1'b1) begin
            checkOutput("tick_timeout", 0, 1);
        end
    endtask

    // Monitor: every accepted event must match the head of the expectation queue.
    always @(negedge clock) begin
        if (resetN && evtValid && evtReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL evt_unexpected: actual id %0d required no event", evtId);
            end else begin
                checkOutput("evt_id_scoreboard", int'(evtId), int'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        resetN   = 1'b0;
        enable   = 1'b0;
        armValid = 1'b0;
        armCh    = '0;
        armTicks = '0;
        evtReady = 1'b1;
        ovfClr   = '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        armPeriodic = 1'b0;
`endif

        #23;
        checkOutput("rst_tick", int'(tickOut), 0);
        checkOutput("rst_active", int'(active), 0);
        checkOutput("rst_evt_valid", int'(evtValid), 0);
        checkOutput("rst_evt_id", int'(evtId), 0);
        checkOutput("rst_ovf", int'(ovf), 0);
        @(negedge clock);
        resetN = 1'b1;
        enable = 1'b1;

        $display("[TB] simultaneous expiry burst");
        expQ.push_back(0);
        expQ.push_back(1);
        expQ.push_back(3);
        waitForTick();
        step();
        applyStimulus(0, 1, 1);
        applyStimulus(1, 1, 1);
        applyStimulus(3, 1, 1);
        checkOutput("burst_tick", int'(tickOut), 1);
        step();
        checkOutput("burst0_valid", int'(evtValid), 1);
        checkOutput("burst0_id", int'(evtId), 0);
        step();
        checkOutput("burst1_valid", int'(evtValid), 1);
        checkOutput("burst1_id", int'(evtId), 1);
        step();
        checkOutput("burst2_valid", int'(evtValid), 1);
        checkOutput("burst2_id", int'(evtId), 3);
        step();
        checkOutput("burst_end_valid", int'(evtValid), 0);

        expQ.push_back(0);
        expQ.push_back(3);
        step();
        applyStimulus(3, 1, 1);
        applyStimulus(0, 1, 1);
        waitForTick();
        step();
        checkOutput("wrap_first_id", int'(evtId), 0);
        step();
        checkOutput("wrap_second_id", int'(evtId), 3);

        $display("[TB] one-shot channel 2, N=3");
        waitForTick();
        step();
        expQ.push_back(2);
        applyStimulus(2, 3, 1);
        waitForTick();
        waitForTick();
        waitForTick();
        checkOutput("oneshot_active_on_tick", int'(active[2]), 1);
        checkOutput("oneshot_valid_on_tick", int'(evtValid), 0);
        step();
        checkOutput("oneshot_valid", int'(evtValid), 1);
        checkOutput("oneshot_id", int'(evtId), 2);
        checkOutput("oneshot_active_drop", int'(active[2]), 0);
        step();
        checkOutput("oneshot_valid_after", int'(evtValid), 0);

        $display("[TB] backpressure and overrun");
        evtReady = 1'b0;
        waitForTick();
        step();
        applyStimulus(0, 1, 1);
        waitForTick();
        step();
        checkOutput("bp_valid1", int'(evtValid), 1);
        checkOutput("bp_id1", int'(evtId), 0);
        applyStimulus(0, 1, 1);
        waitForTick();
        step();
        checkOutput("bp_valid2", int'(evtValid), 1);
        checkOutput("bp_id2", int'(evtId), 0);
        checkOutput("bp_ovf_pending_only", int'(ovf), 0);
        applyStimulus(0, 1, 1);
        waitForTick();
        step();
        checkOutput("bp_valid3", int'(evtValid), 1);
        checkOutput("bp_id3", int'(evtId), 0);
        checkOutput("bp_ovf_set", int'(ovf), 1);
        expQ.push_back(0);
        expQ.push_back(0);
        evtReady = 1'b1;
        step();
        checkOutput("bp_followup_valid", int'(evtValid), 1);
        checkOutput("bp_followup_id", int'(evtId), 0);
        step();
        checkOutput("bp_drained", int'(evtValid), 0);
        checkOutput("bp_ovf_sticky", int'(ovf), 1);
        ovfClr = 4'b0001;
        step();
        ovfClr = 4'b0000;
        checkOutput("bp_ovf_cleared", int'(ovf), 0);

        $display("[TB] arm coincident with tick");
        waitForTick();
        expQ.push_back(2);
        applyStimulus(2, 2, 1);
        waitForTick();
        step();
        checkOutput("coinc_active", int'(active[2]), 1);
        checkOutput("coinc_not_early", int'(evtValid), 0);
        waitForTick();
        step();
        checkOutput("coinc_valid", int'(evtValid), 1);
        checkOutput("coinc_id", int'(evtId), 2);

        $display("[TB] arm on active channel and cancel");
        applyStimulus(1, 5, 1);
        checkOutput("rearm_active", int'(active[1]), 1);
        applyStimulus(1, 3, 0);
        checkOutput("rearm_still_active", int'(active[1]), 1);
        applyStimulus(1, 0, 1);
        checkOutput("cancel_active", int'(active[1]), 0);

        evtReady = 1'b0;
        waitForTick();
        step();
        applyStimulus(2, 1, 1);
        applyStimulus(1, 1, 1);
        waitForTick();
        step();
        checkOutput("cancel_evt_valid", int'(evtValid), 1);
        checkOutput("cancel_evt_id", int'(evtId), 1);
        expQ.push_back(1);
        applyStimulus(2, 0, 1);
        evtReady = 1'b1;
        step();
        checkOutput("cancel_pending_cleared", int'(evtValid), 0);

`ifdef TIMER_SCHED_PERIODIC_EN
        $display("[TB] periodic channel 1, N=2");
        waitForTick();
        step();
        expQ.push_back(1);
        expQ.push_back(1);
        armPeriodic = 1'b1;
        applyStimulus(1, 2, 1);
        armPeriodic = 1'b0;
        waitForTick();
        waitForTick();
        step();
        checkOutput("per_evt1_valid", int'(evtValid), 1);
        checkOutput("per_evt1_id", int'(evtId), 1);
        checkOutput("per_active1", int'(active[1]), 1);
        waitForTick();
        waitForTick();
        step();
        checkOutput("per_evt2_valid", int'(evtValid), 1);
        checkOutput("per_active2", int'(active[1]), 1);
        applyStimulus(1, 0, 1);
        waitForTick();
        waitForTick();
        step();
        checkOutput("per_stopped_active", int'(active[1]), 0);
        checkOutput("per_stopped_valid", int'(evtValid), 0);
`endif

        $display("[TB] reset mid-count");
        waitForTick();
        step();
        applyStimulus(1, 2, 1);
        waitForTick();
        step();
        checkOutput("midrst_active_before", int'(active), 2);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midrst_tick", int'(tickOut), 0);
        checkOutput("midrst_active", int'(active), 0);
        checkOutput("midrst_evt_valid", int'(evtValid), 0);
        checkOutput("midrst_evt_id", int'(evtId), 0);
        checkOutput("midrst_ovf", int'(ovf), 0);
        @(negedge clock);
        resetN = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (tickOut !== 1'b1 && n < 12);
        checkOutput("midrst_first_tick_cycles", n, 4);
        waitForTick();
        waitForTick();
        step();
        checkOutput("midrst_no_revival", int'(active), 0);
        checkOutput("midrst_no_event", int'(evtValid), 0);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
